// File: rtl/divisor_binario_sequencial_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encoding and default operand width live here so shell and bench agree.
package divisor_binario_sequencial_pkg;

    typedef enum logic [1:0] {
        REPOUSO = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int N_PADRAO = 8;

    // Quotient would not fit in N bits (or divisor is zero): reject up front.
    function automatic logic erro_previo(input logic [N_PADRAO-1:0] parte_alta,
                                         input logic [N_PADRAO-1:0] dsr);
        return (dsr == '0) || (parte_alta >= dsr);
    endfunction

endpackage

// File: rtl/divisor_passo.sv
// One combinational restoring-division step: shift {rem,quo} left, then
// subtract the divisor and set the new quotient bit if it fits.
module divisor_passo
    import divisor_binario_sequencial_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] dsr,
    output logic [N:0]   rem_prox,
    output logic [N-1:0] quo_prox
);

    logic [N:0] desloc;
    logic [N:0] dsr_ext;
    logic       cabe;
    // The partial remainder stays below dsr between steps, so its MSB is always 0.
    logic       unused_rem_msb;

    assign unused_rem_msb = rem[N];
    assign desloc         = {rem[N-1:0], quo[N-1]};
    assign dsr_ext        = {1'b0, dsr};
    assign cabe           = (desloc >= dsr_ext);
    assign rem_prox       = cabe ? (desloc - dsr_ext) : desloc;
    assign quo_prox       = {quo[N-2:0], cabe};

endmodule

// File: rtl/divisor_binario_sequencial.sv
// Sequential restoring divider shell: 2N-bit dividend / N-bit divisor, one bit per clock.
// Optional debug port passo is enabled with DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN.
module divisor_binario_sequencial
    import divisor_binario_sequencial_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2*N-1:0]     dividendo,
    input  logic [N-1:0]       divisor,
    output logic [N-1:0]       quociente,
    output logic [N-1:0]       resto,
    output logic               erro,
    output logic               ocupado,
    output logic               pronto
`ifdef DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN
    ,
    output logic [$clog2(N+1)-1:0] passo
`endif
);

    localparam int CW = $clog2(N+1);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    estado_t       estado;
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dsr;
    logic [CW-1:0] cnt;

    logic [N:0]    rem_prox;
    logic [N-1:0]  quo_prox;
    logic          erro_entrada;

    assign erro_entrada = (divisor == '0) || (dividendo[2*N-1:N] >= divisor);

    divisor_passo #(.N(N)) u_passo (
        .rem      (rem),
        .quo      (quo),
        .dsr      (dsr),
        .rem_prox (rem_prox),
        .quo_prox (quo_prox)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain steps within one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= REPOUSO;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            quociente <= '0;
            resto     <= '0;
            erro      <= 1'b0;
        end else begin
            case (estado)
                REPOUSO: begin
                    if (start) begin
                        if (erro_entrada) begin
                            estado    <= FIM;
                            quociente <= '0;
                            resto     <= '0;
                            erro      <= 1'b1;
                        end else begin
                            estado <= CALCULA;
                            rem    <= {1'b0, dividendo[2*N-1:N]};
                            quo    <= dividendo[N-1:0];
                            dsr    <= divisor;
                            cnt    <= '0;
                        end
                    end
                end
                CALCULA: begin
                    if (start) begin
                        // Abort: back to idle with everything cleared; not a new request.
                        estado    <= REPOUSO;
                        rem       <= '0;
                        quo       <= '0;
                        dsr       <= '0;
                        cnt       <= '0;
                        quociente <= '0;
                        resto     <= '0;
                        erro      <= 1'b0;
                    end else begin
                        rem <= rem_prox;
                        quo <= quo_prox;
                        cnt <= cnt + CW'(1);
                        if (cnt == ULTIMO) begin
                            estado    <= FIM;
                            quociente <= quo_prox;
                            resto     <= rem_prox[N-1:0];
                            erro      <= 1'b0;
                        end
                    end
                end
                FIM: begin
                    estado <= REPOUSO;
                end
                default: begin
                    estado <= REPOUSO;
                end
            endcase
        end
    end

    assign ocupado = (estado == CALCULA);
    assign pronto  = (estado == FIM);

`ifdef DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN
    assign passo = (estado == CALCULA) ? (cnt + CW'(1)) : '0;
`endif

endmodule

// File: tb/tb_divisor_binario_sequencial.sv
// Directed self-checking bench for divisor_binario_sequencial with a result scoreboard.
// Also checks the passo debug port when DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN is defined.
module tb_divisor_binario_sequencial;

    localparam int N  = 8;
    localparam int CW = $clog2(N+1);

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         e;
        int           lat;
    } esperado_t;

    logic           clock;
    logic           reset_n;
    logic           start;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quociente;
    logic [N-1:0]   resto;
    logic           erro;
    logic           ocupado;
    logic           pronto;
`ifdef DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN
    logic [CW-1:0]  passo;
`endif

    esperado_t fila[$];
    int tests_run;
    int tests_failed;

    divisor_binario_sequencial #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .quociente (quociente),
        .resto     (resto),
        .erro      (erro),
        .ocupado   (ocupado),
        .pronto    (pronto)
`ifdef DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN
        ,
        .passo     (passo)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic esperado_t modelo(input logic [2*N-1:0] dvd, input logic [N-1:0] ds);
        esperado_t e;
        if (ds == 0 || dvd[2*N-1:N] >= ds) begin
            e.q = '0; e.r = '0; e.e = 1'b1; e.lat = 1;
        end else begin
            e.q = N'(dvd / ds); e.r = N'(dvd % ds); e.e = 1'b0; e.lat = N + 1;
        end
        return e;
    endfunction

    task automatic check_passo(input string tag, input int exp);
`ifdef DIVISOR_BINARIO_SEQUENCIAL_PASSO_EN
        check(tag, 32'(passo), 32'(exp));
`endif
    endtask

    // Launch one division; compare latency, busy window and popped result at pronto.
    task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] ds, input bit hold_fim);
        esperado_t e;
        int ciclos;
        fila.push_back(modelo(dvd, ds));
        @(negedge clock);
        dividendo = dvd; divisor = ds; start = 1'b1;
        @(negedge clock);
        start = 1'b0; dividendo = ~dvd; divisor = ~ds;
        ciclos = 1;
        while (!pronto && ciclos < 20) begin
            check("ocupado_durante", 32'(ocupado), 32'(ciclos <= N));
            check_passo("passo_calcula", ciclos);
            @(negedge clock);
            ciclos++;
        end
        e = fila.pop_front();
        check("pronto_visto", 32'(pronto), 32'd1);
        check("latencia", 32'(ciclos), 32'(e.lat));
        check("ocupado_em_fim", 32'(ocupado), 32'd0);
        check_passo("passo_fim", 0);
        check("quociente", 32'(quociente), 32'(e.q));
        check("resto", 32'(resto), 32'(e.r));
        check("erro", 32'(erro), 32'(e.e));
        if (hold_fim) start = 1'b1;
        @(negedge clock);
        check("pronto_um_ciclo", 32'(pronto), 32'd0);
        check("ocupado_pos_fim", 32'(ocupado), 32'd0);
        check("quociente_mantido", 32'(quociente), 32'(e.q));
        check_passo("passo_repouso", 0);
        start = 1'b0;
    endtask

    initial begin
        int vistos;
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0; start = 1'b0; dividendo = '0; divisor = '0;
        repeat (2) @(negedge clock);
        check("rst_quociente", 32'(quociente), 32'd0);
        check("rst_resto", 32'(resto), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        reset_n = 1'b1;

        run_op(16'd1000, 8'd7, 1'b0);
        run_op(16'hFE00, 8'hFF, 1'b1);
        run_op(16'h1234, 8'h00, 1'b0);
        run_op(16'h0800, 8'h08, 1'b0);

        // Abort: start re-asserted so that edge k+4 sees it in CALCULA.
        @(negedge clock);
        dividendo = 16'd1000; divisor = 8'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_quociente", 32'(quociente), 32'd0);
        check("abort_resto", 32'(resto), 32'd0);
        check("abort_erro", 32'(erro), 32'd0);
        vistos = 0;
        for (int i = 0; i < 12; i++) begin
            if (pronto || ocupado) vistos++;
            @(negedge clock);
        end
        check("abort_sem_pronto", 32'(vistos), 32'd0);
        run_op(16'd255, 8'd1, 1'b0);

        // Asynchronous reset between edges while in CALCULA.
        @(negedge clock);
        dividendo = 16'd1000; divisor = 8'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_quociente", 32'(quociente), 32'd0);
        check("arst_resto", 32'(resto), 32'd0);
        check("arst_erro", 32'(erro), 32'd0);
        check("arst_ocupado", 32'(ocupado), 32'd0);
        check("arst_pronto", 32'(pronto), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        vistos = 0;
        for (int i = 0; i < 12; i++) begin
            if (pronto || ocupado) vistos++;
            @(negedge clock);
        end
        check("arst_sem_pronto", 32'(vistos), 32'd0);
        run_op(16'd100, 8'd9, 1'b0);

        check("fila_vazia", 32'(fila.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
